branch_redirect_ctrl: RTL

Sequential branch-resolution back end for the MIPS pipeline. Consumes the taken/not-taken decision made in ID by the branch condition logic. Converts it into a registered PC redirect that honours the architectural delay slot, plus an IF/ID flush of the single wrong-path fetch and a link-register write for the and-link branches. Sits between ID-stage branch evaluation and the IF next-PC mux. Also keeps saturating branch/taken statistics.

---
 rtl/mips_pkg.sv | 16 +
 rtl/branch_redirect_ctrl_sat_counter.sv | 24 ++
 rtl/branch_redirect_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants
package mips_pkg;

  // Default program-counter width
  localparam int DEF_PC_W = 32;

  // Return address of an and-link branch is the instruction after the delay slot
  localparam int LINK_OFFSET = 8;

  // Branch redirect sequencing states
  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } redirect_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// rtl/branch_redirect_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - registered PC redirect, wrong-path flush and link write
module branch_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic             br_link,
  input  logic [PC_W-1:0]  br_target,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             fetch_stall,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             if_id_flush,
  output logic             link_we,
  output logic [PC_W-1:0]  link_data,
  output logic             busy,
  output logic             err_ds_branch,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  redirect_state_t r_state;
  logic [PC_W-1:0] r_pc_target;
  logic            r_err_ds;
  logic            r_link_we;
  logic [PC_W-1:0] r_link_data;

  logic            w_redirect;
  logic            w_taken_start;

  assign w_redirect    = (r_state == REDIRECT);
  // A branch seen while redirecting is the delay slot and never starts a new redirect
  assign w_taken_start = br_valid && br_taken && !w_redirect;

  // Redirect FSM: latch target on a taken branch, hold while IF is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pc_target <= '0;
      r_err_ds    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (br_valid && br_taken) begin
            r_pc_target <= br_target;
            r_state     <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (br_valid) begin
            r_err_ds <= 1'b1;
          end
          if (!fetch_stall) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Link strobe for and-link branches, taken or not, one cycle after the branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_we   <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_we <= br_valid && br_link;
      if (br_valid && br_link) begin
        r_link_data <= id_pc + PC_W'(LINK_OFFSET);
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_valid),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_taken_start),
    .count (taken_cnt)
  );

  assign pc_sel        = w_redirect;
  assign if_id_flush   = w_redirect;
  assign busy          = w_redirect;
  assign pc_target     = r_pc_target;
  assign link_we       = r_link_we;
  assign link_data     = r_link_data;
  assign err_ds_branch = r_err_ds;

endmodule
